// File: rtl/cmd_tx_pkg.sv
// Shared definitions for the car command transmit path: command indices,
// frame tag, transmitter state encoding and the request arbiter helper.
package cmd_tx_pkg;

    localparam int NUM_CMDS = 10;

    localparam int CMD_RST         = 0;
    localparam int CMD_FORWARD     = 1;
    localparam int CMD_BACKWARD    = 2;
    localparam int CMD_LEFT        = 3;
    localparam int CMD_RIGHT       = 4;
    localparam int CMD_AUTO        = 5;
    localparam int CMD_DANCE       = 6;
    localparam int CMD_SHUTDOWN    = 7;
    localparam int CMD_HEADLIGHT   = 8;
    localparam int CMD_YELLOWFLASH = 9;

    localparam logic [3:0] FRAME_TAG = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Index of the lowest set request; index 0 (the rst command) wins over all others.
    function automatic logic [3:0] lowest_index(input logic [NUM_CMDS-1:0] req);
        lowest_index = 4'd0;
        for (int i = NUM_CMDS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lowest_index = 4'(i);
            end
        end
    endfunction

endpackage

// File: rtl/cmd_frame_tx_if.sv
// Command strobe input and serial-side status outputs of the command transmitter.
// The master side is whoever produces strobes and watches the line; the slave
// side is the transmitter itself.
interface cmd_frame_tx_if;
    import cmd_tx_pkg::*;

    logic [NUM_CMDS-1:0] cmd_pulse;
    logic                tx;
    logic                busy;
    logic                tx_done;
    logic                overflow;

    modport master (
        output cmd_pulse,
        input  tx,
        input  busy,
        input  tx_done,
        input  overflow
    );

    modport slave (
        input  cmd_pulse,
        output tx,
        output busy,
        output tx_done,
        output overflow
    );

endinterface

// File: rtl/cmd_uart_shifter.sv
// Bit-timing datapath for the command UART: baud counter, data bit index and
// the 8-bit shift register holding the frame byte. The owning FSM decides which
// phase of the frame is active; this block only paces it and supplies bits.
// Optional feature macro: CMD_FRAME_TX_PARITY_EN adds the even-parity output.
module cmd_uart_shifter #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_byteIn,
    input  logic       i_active,
    input  logic       i_shift,
    input  logic       i_countBits,
    output logic       o_bitTick,
    output logic       o_dataBit,
    output logic       o_lastBit
`ifdef CMD_FRAME_TX_PARITY_EN
    ,
    output logic       o_parity
`endif
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_baudCnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shiftReg;

    assign o_bitTick = i_active && (r_baudCnt == LAST_CNT);
    assign o_dataBit = r_shiftReg[0];
    assign o_lastBit = (r_bitIdx == 3'd7);

    // Baud counter runs 0..CLKS_PER_BIT-1 while a frame is active and restarts at every bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baudCnt <= '0;
        end else if (i_load || !i_active || o_bitTick) begin
            r_baudCnt <= '0;
        end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
        end
    end

    // Shift register always presents the next bit to send at bit 0; it advances as each bit is handed out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shiftReg <= '0;
        end else if (i_load) begin
            r_shiftReg <= i_byteIn;
        end else if (i_shift && o_bitTick) begin
            r_shiftReg <= {1'b0, r_shiftReg[7:1]};
        end
    end

    // Data bit index counts the eight data bits and naturally wraps 7 -> 0 as the data phase ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitIdx <= '0;
        end else if (i_load) begin
            r_bitIdx <= '0;
        end else if (i_countBits && o_bitTick) begin
            r_bitIdx <= r_bitIdx + 3'd1;
        end
    end

`ifdef CMD_FRAME_TX_PARITY_EN
    logic r_parity;

    assign o_parity = r_parity;

    // Even parity is captured from the whole byte at load time, before shifting destroys it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (i_load) begin
            r_parity <= ^i_byteIn;
        end
    end
`endif

endmodule

// File: rtl/cmd_frame_tx.sv
// Transmit side of the car command link. Latches one-cycle command strobes as
// pending requests and sends them one at a time, lowest index first, as UART
// frames {A, code} on the tx line.
// Optional feature macro: CMD_FRAME_TX_PARITY_EN inserts an even-parity bit (8E1).
module cmd_frame_tx
    import cmd_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic           clk,
    input  logic           rst,
    cmd_frame_tx_if.slave  bus
);

    tx_state_t           r_state;
    logic [NUM_CMDS-1:0] r_pending;
    logic                r_overflow;
    logic                r_tx;
    logic                r_busy;
    logic                r_txDone;

    logic                w_load;
    logic [NUM_CMDS-1:0] w_grant;
    logic [3:0]          w_code;
    logic [7:0]          w_byte;
    logic                w_bitTick;
    logic                w_dataBit;
    logic                w_lastBit;
    logic                w_active;
    logic                w_shift;
    logic                w_countBits;
`ifdef CMD_FRAME_TX_PARITY_EN
    logic                w_parity;
`endif

    assign w_load      = (r_state == IDLE) && (r_pending != '0);
    assign w_grant     = w_load ? (r_pending & (~r_pending + 10'd1)) : '0;
    assign w_code      = lowest_index(r_pending);
    assign w_byte      = {FRAME_TAG, w_code};
    assign w_active    = (r_state != IDLE);
    assign w_shift     = (r_state == START) || (r_state == DATA);
    assign w_countBits = (r_state == DATA);

    assign bus.tx       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.tx_done  = r_txDone;
    assign bus.overflow = r_overflow;

    cmd_uart_shifter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_byteIn    (w_byte),
        .i_active    (w_active),
        .i_shift     (w_shift),
        .i_countBits (w_countBits),
        .o_bitTick   (w_bitTick),
        .o_dataBit   (w_dataBit),
        .o_lastBit   (w_lastBit)
`ifdef CMD_FRAME_TX_PARITY_EN
        ,
        .o_parity    (w_parity)
`endif
    );

    // Pending requests: a new strobe always wins over the clear of the bit being selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | bus.cmd_pulse;
        end
    end

    // Sticky overflow: a strobe landed on a request that is still waiting to be sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if ((bus.cmd_pulse & r_pending & ~w_grant) != '0) begin
            r_overflow <= 1'b1;
        end
    end

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_txDone <= 1'b0;
        end else begin
            r_txDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_load) begin
                        r_state <= START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bitTick) begin
                        r_state <= DATA;
                        r_tx    <= w_dataBit;
                    end
                end
                DATA: begin
                    if (w_bitTick) begin
                        if (w_lastBit) begin
`ifdef CMD_FRAME_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= w_parity;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_tx <= w_dataBit;
                        end
                    end
                end
                PARITY: begin
                    if (w_bitTick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_bitTick) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_txDone <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Self-checking bench for cmd_frame_tx. A frame-level reference model predicts
// the line, busy, done and overflow every cycle; a small line decoder turns the
// DUT's tx back into bytes for order and content checks.
module tb_cmd_frame_tx;
    import cmd_tx_pkg::*;

    localparam int CPB = 4;
`ifdef CMD_FRAME_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic clk;
    logic rst;

    cmd_frame_tx_if busIf ();

    cmd_frame_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int cycleNo    = 0;

    // Reference model state
    logic [9:0]  mPending;
    bit          mOverflow;
    bit          mActive;
    int          mPos;
    logic [10:0] mBits;
    bit          mDone;
    logic [7:0]  mSent[$];

    // Observation logs and line decoder state
    int          fallCycles[$];
    int          doneCycles[$];
    logic [7:0]  rxQ[$];
    logic        rxParQ[$];
    bit          prevBusy;
    bit          rxActive;
    int          rxCnt;
    logic [7:0]  rxShift;
    logic        rxPar;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleNo);
        end
    endtask

    function automatic int lowestPending(input logic [9:0] v);
        for (int i = 0; i < 10; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] rxAt(input int i);
        if (i < rxQ.size()) return rxQ[i];
        return 8'h00;
    endfunction

    task automatic clearLogs();
        fallCycles.delete();
        doneCycles.delete();
        rxQ.delete();
        rxParQ.delete();
        mSent.delete();
    endtask

    task automatic modelReset();
        mPending  = '0;
        mOverflow = 0;
        mActive   = 0;
        mPos      = 0;
        mBits     = '1;
        mDone     = 0;
        prevBusy  = 0;
        rxActive  = 0;
        rxCnt     = 0;
        clearLogs();
    endtask

    // One clock edge of the frame-level model: frames take FRAME_CYC cycles and
    // a new frame can only begin on an edge where the line was already idle.
    task automatic modelEdge(input logic [9:0] p);
        logic [9:0] grant;
        logic [7:0] b;
        int idx;
        grant = '0;
        mDone = 0;
        if (mActive) begin
            mPos++;
            if (mPos == FRAME_CYC) begin
                mActive = 0;
                mDone   = 1;
            end
        end else if (mPending != '0) begin
            idx = lowestPending(mPending);
            grant[idx] = 1'b1;
            b = {4'hA, 4'(idx)};
            mSent.push_back(b);
            mBits = '1;
            mBits[0] = 1'b0;
            for (int i = 0; i < 8; i++) mBits[1 + i] = b[i];
`ifdef CMD_FRAME_TX_PARITY_EN
            mBits[9] = ^b;
`endif
            mActive = 1;
            mPos    = 0;
        end
        if ((p & mPending & ~grant) != '0) mOverflow = 1;
        mPending = (mPending & ~grant) | p;
    endtask

    task automatic observeLine();
        int slot;
        if (busIf.busy && !prevBusy) fallCycles.push_back(cycleNo);
        prevBusy = busIf.busy;
        if (busIf.tx_done) doneCycles.push_back(cycleNo);
        if (!rxActive) begin
            if (busIf.tx == 1'b0) begin
                rxActive = 1;
                rxCnt    = 0;
                rxShift  = '0;
                rxPar    = 1'b0;
            end
        end else begin
            rxCnt++;
            if ((rxCnt % CPB) == (CPB / 2)) begin
                slot = rxCnt / CPB;
                if (slot >= 1 && slot <= 8) begin
                    rxShift[slot - 1] = busIf.tx;
                end else if (slot == NBITS - 1) begin
                    checkOutput("stopBit", busIf.tx, 1);
                    rxQ.push_back(rxShift);
                    rxParQ.push_back(rxPar);
                    rxActive = 0;
                end else if (slot == 9) begin
                    rxPar = busIf.tx;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [9:0] p);
        logic expTx;
        @(negedge clk);
        busIf.cmd_pulse = p;
        @(posedge clk);
        cycleNo++;
        modelEdge(p);
        #1;
        busIf.cmd_pulse = '0;
        expTx = mActive ? mBits[mPos / CPB] : 1'b1;
        checkOutput("tx", busIf.tx, expTx);
        checkOutput("busy", busIf.busy, mActive);
        checkOutput("tx_done", busIf.tx_done, mDone);
        checkOutput("overflow", busIf.overflow, mOverflow);
        observeLine();
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0);
    endtask

    initial begin
        int c0;
        logic [9:0] p;

        rst = 1'b1;
        busIf.cmd_pulse = '0;
        modelReset();
        #1;
        checkOutput("rstTx", busIf.tx, 1);
        checkOutput("rstBusy", busIf.busy, 0);
        checkOutput("rstDone", busIf.tx_done, 0);
        checkOutput("rstOverflow", busIf.overflow, 0);
        #26;
        rst = 1'b0;

        $display("[TB] idle after reset");
        runIdle(20);

        $display("[TB] single command LEFT");
        clearLogs();
        applyStimulus(10'(1 << CMD_LEFT));
        c0 = cycleNo;
        runIdle(FRAME_CYC + 10);
        checkOutput("t2Frames", fallCycles.size(), 1);
        checkOutput("t2FallAt", (fallCycles.size() > 0) ? fallCycles[0] - c0 : -1, 1);
        checkOutput("t2Dones", doneCycles.size(), 1);
        checkOutput("t2Length", (doneCycles.size() > 0 && fallCycles.size() > 0) ?
                    doneCycles[0] - fallCycles[0] : -1, FRAME_CYC);
        checkOutput("t2Byte", rxAt(0), 8'hA3);
`ifdef CMD_FRAME_TX_PARITY_EN
        checkOutput("t2Parity", (rxParQ.size() > 0) ? rxParQ[0] : 1'bx, 0);
`endif

        $display("[TB] simultaneous FORWARD and YELLOWFLASH");
        clearLogs();
        applyStimulus(10'((1 << CMD_FORWARD) | (1 << CMD_YELLOWFLASH)));
        runIdle(2 * FRAME_CYC + 10);
        checkOutput("t3Count", rxQ.size(), 2);
        checkOutput("t3First", rxAt(0), 8'hA1);
        checkOutput("t3Second", rxAt(1), 8'hA9);
        checkOutput("t3Gap", (fallCycles.size() > 1 && doneCycles.size() > 0) ?
                    fallCycles[1] - doneCycles[0] : -1, 1);
        checkOutput("t3Overflow", busIf.overflow, 0);

        $display("[TB] duplicate AUTO during a frame");
        clearLogs();
        applyStimulus(10'(1 << CMD_LEFT));
        runIdle(5);
        applyStimulus(10'(1 << CMD_AUTO));
        runIdle(5);
        applyStimulus(10'(1 << CMD_AUTO));
        runIdle(2 * FRAME_CYC + 10);
        checkOutput("t4Overflow", busIf.overflow, 1);
        checkOutput("t4Count", rxQ.size(), 2);
        checkOutput("t4First", rxAt(0), 8'hA3);
        checkOutput("t4Second", rxAt(1), 8'hA5);

        $display("[TB] reset during data bit 4");
        clearLogs();
        applyStimulus(10'(1 << CMD_LEFT));
        c0 = cycleNo;
        runIdle(5);
        applyStimulus(10'(1 << CMD_SHUTDOWN));
        while (cycleNo < c0 + 1 + CPB * 5) applyStimulus('0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5Tx", busIf.tx, 1);
        checkOutput("t5Busy", busIf.busy, 0);
        checkOutput("t5Overflow", busIf.overflow, 0);
        modelReset();
        #1;
        rst = 1'b0;
        runIdle(2 * FRAME_CYC + 10);
        checkOutput("t5NoFrames", fallCycles.size(), 0);
        checkOutput("t5NoBytes", rxQ.size(), 0);

        $display("[TB] single command RST");
        clearLogs();
        applyStimulus(10'(1 << CMD_RST));
        runIdle(FRAME_CYC + 10);
        checkOutput("t6Byte", rxAt(0), 8'hA0);
        checkOutput("t6Length", (doneCycles.size() > 0 && fallCycles.size() > 0) ?
                    doneCycles[0] - fallCycles[0] : -1, FRAME_CYC);
`ifdef CMD_FRAME_TX_PARITY_EN
        checkOutput("t6Parity", (rxParQ.size() > 0) ? rxParQ[0] : 1'bx, 0);
`endif

        $display("[TB] random strobes");
        clearLogs();
        for (int n = 0; n < 3000; n++) begin
            p = '0;
            if ($urandom_range(0, 5) == 0) p[$urandom_range(0, 9)] = 1'b1;
            if ($urandom_range(0, 3) == 0) p[$urandom_range(0, 9)] = 1'b1;
            applyStimulus(p);
        end
        runIdle(12 * (FRAME_CYC + 1));
        checkOutput("rndCount", rxQ.size(), mSent.size());
        for (int i = 0; i < mSent.size(); i++) begin
            checkOutput("rndByte", rxAt(i), mSent[i]);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
